// File: rtl/cluster_frame_tx.sv
// rtl/cluster_frame_tx.sv - per-BX cluster frame buffer and beat serializer
module cluster_frame_tx #(
    parameter int CLUSTER_BITS = 14,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                      clock4x,
    input  logic                      reset,
    input  logic                      bx_strobe_i,
    input  logic [10:0]               cnt_i,
    input  logic                      overflow_i,
    input  logic [8*CLUSTER_BITS-1:0] clusters_i,
    input  logic                      link_ready_i,
    output logic [55:0]               frame_data_o,
    output logic                      frame_valid_o,
    output logic                      frame_sof_o,
    output logic                      frame_eof_o,
    output logic [7:0]                seq_o,
    output logic [15:0]               dropped_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 8 * CLUSTER_BITS;
    localparam int PW = 4 * CLUSTER_BITS;
    localparam logic [AW:0] FILL_ZERO = '0;
    localparam logic [AW:0] FILL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FILL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, PAY0, PAY1} state_t;

    // BX record storage; emptiness is tracked by the pointers, so no reset
    logic [10:0]   cnt_mem [FIFO_DEPTH];
    logic          ovf_mem [FIFO_DEPTH];
    logic [CW-1:0] clu_mem [FIFO_DEPTH];
    logic [7:0]    seq_mem [FIFO_DEPTH];

    state_t        state_q, state_d;
    logic [55:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    seq_q, seq_d;
    logic [15:0]   dropped_q, dropped_d;

    logic [AW:0]   fill;
    logic          xfer, pop, accept, has_next;
    logic [AW-1:0] rd_idx, next_idx, ld_idx, wr_idx;
    logic [10:0]   ld_cnt;
    logic [1:0]    ld_nb, head_nb;
    logic [55:0]   ld_hdr;
    logic [CW-1:0] head_clu;
    logic [PW-1:0] grp0, grp1;

    function automatic logic [1:0] nbeats_of(input logic [10:0] c);
        if (c == 11'd0)
            return 2'd0;
        else if (c <= 11'd4)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    assign fill     = wr_ptr_q - rd_ptr_q;
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign next_idx = rd_idx + 1'b1;

    // Handshake, capture decision and the header/payload beat candidates
    always_comb begin
        xfer     = valid_q & link_ready_i;
        pop      = xfer & eof_q;
        accept   = bx_strobe_i & ((fill != FILL_FULL) | pop);
        // After a pop the following record becomes the head of the queue
        has_next = pop ? (fill > FILL_ONE) : (fill != FILL_ZERO);
        ld_idx   = pop ? next_idx : rd_idx;
        ld_cnt   = cnt_mem[ld_idx];
        ld_nb    = nbeats_of(ld_cnt);
        ld_hdr   = {8'hBC, seq_mem[ld_idx], ld_cnt, ovf_mem[ld_idx], ld_nb, 26'd0};
        head_nb  = nbeats_of(cnt_mem[rd_idx]);
        head_clu = clu_mem[rd_idx];
        grp0     = head_clu[0 +: PW];
        grp1     = head_clu[PW +: PW];
    end

    // Next-state for the frame FSM, registered beat outputs and counters
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, accept};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        seq_d     = bx_strobe_i ? seq_q + 8'd1 : seq_q;
        dropped_d = dropped_q;
        if (bx_strobe_i && !accept && dropped_q != 16'hFFFF)
            dropped_d = dropped_q + 16'd1;

        if (state_q == IDLE || pop) begin
            // Start the next frame straight away if one is queued
            if (has_next) begin
                state_d = HDR;
                data_d  = ld_hdr;
                valid_d = 1'b1;
                sof_d   = 1'b1;
                eof_d   = (ld_nb == 2'd0);
            end else begin
                state_d = IDLE;
                data_d  = '0;
                valid_d = 1'b0;
                sof_d   = 1'b0;
                eof_d   = 1'b0;
            end
        end else if (xfer) begin
            case (state_q)
                HDR: begin
                    state_d = PAY0;
                    data_d  = 56'(grp0);
                    sof_d   = 1'b0;
                    eof_d   = (head_nb == 2'd1);
                end
                PAY0: begin
                    state_d = PAY1;
                    data_d  = 56'(grp1);
                    sof_d   = 1'b0;
                    eof_d   = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Record write into the frame buffer on an accepted strobe
    always_ff @(posedge clock4x) begin
        if (accept) begin
            cnt_mem[wr_idx] <= cnt_i;
            ovf_mem[wr_idx] <= overflow_i;
            clu_mem[wr_idx] <= clusters_i;
            seq_mem[wr_idx] <= seq_q;
        end
    end

    // State, output and counter registers; reset aborts any frame in flight
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            seq_q     <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            seq_q     <= seq_d;
            dropped_q <= dropped_d;
        end
    end

    assign frame_data_o  = data_q;
    assign frame_valid_o = valid_q;
    assign frame_sof_o   = sof_q;
    assign frame_eof_o   = eof_q;
    assign seq_o         = seq_q;
    assign dropped_o     = dropped_q;

endmodule

// File: tb/tb_cluster_frame_tx.sv
// tb/tb_cluster_frame_tx.sv - directed bench for cluster_frame_tx
module tb_cluster_frame_tx;

    logic          clock4x = 1'b0;
    logic          reset = 1'b1;
    logic          bx_strobe_i = 1'b0;
    logic [10:0]   cnt_i = '0;
    logic          overflow_i = 1'b0;
    logic [111:0]  clusters_i = '0;
    logic          link_ready_i = 1'b0;
    logic [55:0]   frame_data_o;
    logic          frame_valid_o;
    logic          frame_sof_o;
    logic          frame_eof_o;
    logic [7:0]    seq_o;
    logic [15:0]   dropped_o;

    int tests = 0;
    int fails = 0;

    cluster_frame_tx #(.CLUSTER_BITS(14), .FIFO_DEPTH(2)) dut (
        .clock4x       (clock4x),
        .reset         (reset),
        .bx_strobe_i   (bx_strobe_i),
        .cnt_i         (cnt_i),
        .overflow_i    (overflow_i),
        .clusters_i    (clusters_i),
        .link_ready_i  (link_ready_i),
        .frame_data_o  (frame_data_o),
        .frame_valid_o (frame_valid_o),
        .frame_sof_o   (frame_sof_o),
        .frame_eof_o   (frame_eof_o),
        .seq_o         (seq_o),
        .dropped_o     (dropped_o)
    );

    always #5 clock4x = ~clock4x;

    task automatic tick;
        @(posedge clock4x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] hdr(input logic [7:0] s, input logic [10:0] c,
                                        input logic o, input logic [1:0] nb);
        return {8'hBC, s, c, o, nb, 26'd0};
    endfunction

    function automatic logic [63:0] beat_now();
        return {5'd0, frame_valid_o, frame_sof_o, frame_eof_o, frame_data_o};
    endfunction

    function automatic logic [63:0] beat_exp(input logic s, input logic e, input logic [55:0] d);
        return {5'd0, 1'b1, s, e, d};
    endfunction

    // One frame with ready held high: header, nb payload beats, then idle
    task automatic run_frame(input string tag, input logic [10:0] c, input logic o,
                             input logic [111:0] cl, input logic [1:0] nb, input logic [7:0] s);
        logic [55:0] p;
        cnt_i = c; overflow_i = o; clusters_i = cl;
        link_ready_i = 1'b1;
        bx_strobe_i = 1'b1;
        tick;
        bx_strobe_i = 1'b0;
        tick;
        chk({tag, "_hdr"}, beat_now(), beat_exp(1'b1, nb == 2'd0, hdr(s, c, o, nb)));
        for (int k = 0; k < int'(nb); k++) begin
            tick;
            p = cl[k*56 +: 56];
            chk({tag, "_pay"}, beat_now(), beat_exp(1'b0, k == int'(nb) - 1, p));
        end
        tick;
        chk({tag, "_idle"}, {63'd0, frame_valid_o}, 64'd0);
    endtask

    logic [111:0] cl_a;
    logic [111:0] cl_b;
    logic [58:0]  got [8];
    int           ngot;

    initial begin
        cl_a = {14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h033, 14'h022, 14'h011};
        cl_b = {14'h107, 14'h106, 14'h105, 14'h104, 14'h103, 14'h102, 14'h101, 14'h100};

        tick; tick;
        chk("reset_beat", beat_now(), 64'd0);
        chk("reset_seq", {56'd0, seq_o}, 64'd0);
        chk("reset_drop", {48'd0, dropped_o}, 64'd0);
        reset = 1'b0;
        tick;

        run_frame("cnt0", 11'd0, 1'b0, 112'd0, 2'd0, 8'd0);
        run_frame("cnt3", 11'd3, 1'b0, cl_a, 2'd1, 8'd1);
        run_frame("cnt12", 11'd12, 1'b1, cl_b, 2'd2, 8'd2);
        run_frame("cnt4", 11'd4, 1'b0, cl_b, 2'd1, 8'd3);
        run_frame("cnt5", 11'd5, 1'b0, cl_b, 2'd2, 8'd4);
        run_frame("cnt1536", 11'd1536, 1'b1, cl_b, 2'd2, 8'd5);
        chk("seq_after_six", {56'd0, seq_o}, 64'd6);

        // Stall: five strobes with ready low, two buffered, three dropped
        reset = 1'b1;
        tick;
        reset = 1'b0;
        link_ready_i = 1'b0;
        cnt_i = 11'd0; overflow_i = 1'b0; clusters_i = '0;
        for (int k = 0; k < 5; k++) begin
            bx_strobe_i = 1'b1;
            tick;
            bx_strobe_i = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick;
                chk("stall_hold", beat_now(), beat_exp(1'b1, 1'b1, hdr(8'd0, 11'd0, 1'b0, 2'd0)));
            end
        end
        chk("stall_dropped", {48'd0, dropped_o}, 64'd3);
        chk("stall_seq", {56'd0, seq_o}, 64'd5);
        // Ready returns together with a strobe while full: capture is kept
        link_ready_i = 1'b1;
        bx_strobe_i = 1'b1;
        tick;
        bx_strobe_i = 1'b0;
        chk("resume_seq1", beat_now(), beat_exp(1'b1, 1'b1, hdr(8'd1, 11'd0, 1'b0, 2'd0)));
        chk("resume_dropped", {48'd0, dropped_o}, 64'd3);
        tick;
        chk("resume_seq5", beat_now(), beat_exp(1'b1, 1'b1, hdr(8'd5, 11'd0, 1'b0, 2'd0)));
        tick;
        chk("resume_idle", {63'd0, frame_valid_o}, 64'd0);
        chk("resume_seqo", {56'd0, seq_o}, 64'd6);

        // Ready toggling every cycle during a three-beat frame
        cnt_i = 11'd8; clusters_i = cl_b;
        link_ready_i = 1'b0;
        bx_strobe_i = 1'b1;
        tick;
        bx_strobe_i = 1'b0;
        ngot = 0;
        for (int i = 0; i < 24; i++) begin
            link_ready_i = ~link_ready_i;
            if (frame_valid_o && link_ready_i) begin
                if (ngot < 8) got[ngot] = {frame_valid_o, frame_sof_o, frame_eof_o, frame_data_o};
                ngot++;
            end
            tick;
        end
        chk("toggle_count", 64'(ngot), 64'd3);
        chk("toggle_b0", {5'd0, got[0]}, beat_exp(1'b1, 1'b0, hdr(8'd6, 11'd8, 1'b0, 2'd2)));
        chk("toggle_b1", {5'd0, got[1]}, beat_exp(1'b0, 1'b0, cl_b[55:0]));
        chk("toggle_b2", {5'd0, got[2]}, beat_exp(1'b0, 1'b1, cl_b[111:56]));

        // Reset while the first payload beat is on the link
        link_ready_i = 1'b1;
        bx_strobe_i = 1'b1;
        tick;
        bx_strobe_i = 1'b0;
        tick;
        tick;
        chk("pre_reset_pay0", beat_now(), beat_exp(1'b0, 1'b0, cl_b[55:0]));
        chk("pre_reset_drop", {48'd0, dropped_o}, 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_beat", beat_now(), 64'd0);
        chk("midreset_seq", {56'd0, seq_o}, 64'd0);
        chk("midreset_drop", {48'd0, dropped_o}, 64'd0);
        tick;
        reset = 1'b0;
        tick;
        chk("post_reset_idle", {63'd0, frame_valid_o}, 64'd0);
        run_frame("post_reset", 11'd2, 1'b0, cl_a, 2'd1, 8'd0);
        chk("post_reset_drop", {48'd0, dropped_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cluster_frame_tx.md
Name: cluster_frame_tx

Overview:
- Transmit end of the per-bunch-crossing cluster path.
- Once per BX, captures the cluster count and overflow flag from the cluster counter, plus the 8 cluster words from the cluster finder.
- Serializes them as a framed beat stream with valid/ready flow control toward the trigger-link serializer.
- Includes a small frame buffer so link back-pressure does not stall capture; frames that cannot be buffered are dropped and counted.

Parameters:
- CLUSTER_BITS, 14, width of one cluster word (addr[10:0], size[2:0]).
- FIFO_DEPTH, 2, number of BX records buffered (power of 2, ≥2).

Ports:
- clock4x  input  1  fabric clock, 4× the BX rate.
- reset  input  1  asynchronous, active-high reset.
- bx_strobe_i  input  1  one-cycle pulse marking valid BX data on the inputs; at most one per 4 cycles.
- cnt_i  input  11  cluster count for this BX, 0..1536.
- overflow_i  input  1  count > 8 flag.
- clusters_i  input  8*CLUSTER_BITS  cluster slots 0..7; slot 0 is in the LSBs.
- link_ready_i  input  1  downstream accepts the current beat.
- frame_data_o  output  56  beat payload.
- frame_valid_o  output  1  beat valid.
- frame_sof_o  output  1  first beat (header) of a frame.
- frame_eof_o  output  1  last beat of a frame.
- seq_o  output  8  sequence number of the next BX to be captured.
- dropped_o  output  16  saturating count of dropped frames.

Behaviour:
- Reset values: every output is 0; the FIFO is empty; the FSM is in IDLE. Reset asserted mid-frame aborts the frame with no trailing beats; after release, the next frame starts with a header.
- Capture, on a clock4x edge with bx_strobe_i=1:
  - If the FIFO is not full, or a pop occurs on the same edge, store {cnt_i, overflow_i, clusters_i, seq}.
  - Otherwise drop the frame and increment dropped_o, saturating at 0xFFFF.
  - seq wraps 255→0 and increments on every strobe, accepted or dropped, so the receiver can detect gaps.
- Beat count: nbeats = 0 if cnt_i=0; 1 if cnt_i is 1..4; 2 if cnt_i ≥ 5, with cnt_i saturated to 8.
- Beat formats:
  - Header beat: [55:48]=8'hBC, [47:40]=seq, [39:29]=cnt (raw 11 bits, not saturated), [28]=overflow, [27:26]=nbeats, [25:0]=0.
  - Payload beat k (k=0,1): clusters[4k..4k+3], with slot 4k in [13:0].
- FSM states: IDLE, HDR, PAY0, PAY1.
  - IDLE → HDR when the FIFO is non-empty. HDR is registered and presented on the edge after capture, so a frame captured at edge N is valid in the cycle following edge N+1.
  - HDR → IDLE on transfer if nbeats=0; otherwise HDR → PAY0.
  - PAY0 → PAY1 on transfer if nbeats=2; otherwise PAY0 → IDLE.
  - PAY1 → IDLE on transfer.
  - At the final transfer, if the FIFO holds another record, go directly to HDR with no idle bubble.
- Handshake:
  - A transfer occurs when frame_valid_o=1 and link_ready_i=1.
  - frame_data_o, frame_sof_o and frame_eof_o are held stable while valid=1 and ready=0.
  - valid never deasserts without a transfer.
- Framing flags: sof=1 only on the header. eof=1 on the last beat; for nbeats=0 the header carries both sof and eof.
- FIFO pop: the record pops on the transfer of the frame's last beat.
- Simultaneous pop and capture with the FIFO full: the capture is accepted and nothing is dropped.
- Throughput: with ready held at 1, at most 3 beats per frame fit in the 4-cycle BX period, so no drops occur.

Test Plan:
- Reset, then a strobe with cnt=0, ready=1 → one beat: 0xBC, seq=0, cnt=0, nbeats=0, sof=eof=1.
- cnt=3, clusters 0x0011,0x0022,0x0033 in slots 0..2 → header nbeats=1, then payload [41:0]={0x0033,0x0022,0x0011} with eof=1.
- cnt=12, overflow=1 → header cnt field=12, ovf=1, nbeats=2; payload 0 carries slots 0–3 and payload 1 carries slots 4–7 with eof=1.
- ready=0 for 20 cycles with strobes every 4 cycles → 2 records buffered, dropped_o=3, header seq values 0,1, then the next received frame shows seq=5 after ready returns; data is stable while stalled.
- Ready toggling 1/0 every cycle during a 3-beat frame → each beat is emitted exactly once, in order, with no duplicates.
- Assert reset during PAY0 → outputs go to 0 immediately; after release, a strobe produces a header with seq=0 and dropped_o=0.
